// File: rtl/wl_seq_pkg.sv
// Shared types and constants for the wordline address sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wl_seq_pkg;

  // Default row-address width; the decoder it feeds is 4-to-16.
  localparam int ADDR_W_DEFAULT = 4;

  // Number of addressable rows for the default width.
  localparam int ROWS = 1 << ADDR_W_DEFAULT;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } wl_seq_state_t;

endpackage

// File: rtl/wl_addr_step.sv
// Next-address / next-index step for the wordline sequencer, with wrap and last-flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to apply the step.
module wl_addr_step
  import wl_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              loop_i,
  output logic [ADDR_W-1:0] addr_nxt_o,
  output logic [ADDR_W-1:0] idx_nxt_o,
  output logic              last_o
);

  logic is_last;

  // Last element of a pass: restart from the start row when looping,
  // otherwise advance by the stride; the sum is kept at ADDR_W bits so the
  // carry drops out and rows wrap modulo 2^ADDR_W.
  always_comb begin
    is_last    = (idx_i == count_i);
    addr_nxt_o = addr_i + stride_i;
    idx_nxt_o  = idx_i + ADDR_W'(1);
    if (is_last && loop_i) begin
      addr_nxt_o = start_i;
      idx_nxt_o  = '0;
    end
    last_o = is_last;
  end

endmodule

// File: rtl/wl_addr_sequencer.sv
// Row-address stream generator feeding the 4-to-16 wordline decoder (build option WL_SEQ_STRIDE_EN adds cmd_stride).
// Latency: first address valid the cycle after command accept; one address per cycle; done one cycle after the last handshake.
// Backpressure: addr held stable while addr_valid && !addr_ready; commands only accepted in IDLE (cmd_ready), never queued.
module wl_addr_sequencer
  import wl_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [ADDR_W-1:0] cmd_count,
`ifdef WL_SEQ_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride,
`endif
  input  logic              cmd_loop,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
);

  wl_seq_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              loop_q, loop_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] stride_w;

  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] step_idx;
  logic              step_last;
  logic              hs;

`ifdef WL_SEQ_STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;

  // Stride captured with the command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end

  // Stride latches only when a command is taken.
  always_comb begin
    stride_d = stride_q;
    if (state_q == IDLE && cmd_valid) begin
      stride_d = cmd_stride;
    end
    stride_w = stride_q;
  end
`else
  // Fixed unit stride: plain linear sweep.
  always_comb begin
    stride_w = ADDR_W'(1);
  end
`endif

  wl_addr_step #(
    .ADDR_W (ADDR_W)
  ) u_step (
    .addr_i     (addr_q),
    .idx_i      (idx_q),
    .start_i    (start_q),
    .count_i    (count_q),
    .stride_i   (stride_w),
    .loop_i     (loop_q),
    .addr_nxt_o (step_addr),
    .idx_nxt_o  (step_idx),
    .last_o     (step_last)
  );

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      start_q <= '0;
      count_q <= '0;
      loop_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      count_q <= count_d;
      loop_q  <= loop_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign hs = valid_q && addr_ready;

  // Next-state logic; output flags are derived from the next state so they
  // come straight out of flops with no path from addr_ready.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    start_d = start_q;
    count_d = count_q;
    loop_d  = loop_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          start_d = cmd_start;
          count_d = cmd_count;
          loop_d  = cmd_loop;
          addr_d  = cmd_start;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          // A same-cycle handshake still counts; the address just stays put.
          state_d = FIN;
        end else if (hs) begin
          if (step_last && !loop_q) begin
            state_d = FIN;
          end else begin
            addr_d = step_addr;
            idx_d  = step_idx;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == FIN);
    ready_d = (state_d == IDLE);
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_ready  = ready_q;

endmodule
